pc_control_unit: RTL and testbench
==================================

# pc_control_unit

Parametrised program-counter and control-transfer unit for the single-cycle/multicycle CPU datapath. It owns the PC register and resolves sequential advance, J, JR and four compare-branches (BEQ/BNE/BGT/BLT) on register *values*. It optionally models a one-instruction branch delay slot. It sits between instruction decode (op, offset, target, register-file read data) and the instruction-memory address port.

## Interface
- ADDR_W, 32, PC width; must be ≥ 28.
- DATA_W, 32, register-file data width used for compares and JR.
- RESET_VECTOR, 0, PC value after reset; must be word aligned.
- DELAY_SLOT, 1, 1 = one delay-slot instruction after a taken transfer; 0 = immediate redirect.
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  freeze PC, FSM and latched target.
- valid  in  1  decoded instruction present; when 0, op is treated as SEQ.
- op  in  3  SEQ=0, J=1, JR=2, BEQ=3, BNE=4, BGT=5, BLT=6; 7 is treated as SEQ.
- rs_val  in  DATA_W  value of register s.
- rt_val  in  DATA_W  value of register t.
- offset  in  16  branch offset, in words, signed.
- target  in  26  jump target index.
- pc  out  ADDR_W  current PC (registered).
- pc_plus4  out  ADDR_W  pc+4 (combinational).
- taken  out  1  control transfer resolved this cycle (combinational).
- addr_err  out  1  registered one-cycle pulse: JR to a misaligned address.
- slot_err  out  1  registered one-cycle pulse: control op ignored inside a delay slot.

## Operation
- Branch target: pc_plus4 + (sign-extended offset << 2), computed modulo 2^ADDR_W with wrap-around permitted.
- J target: {pc_plus4[ADDR_W-1:28], target, 2'b00}.
- JR target: rs_val[ADDR_W-1:0] with bits [1:0] forced to 0.
  - If rs_val[1:0] ≠ 0, addr_err pulses and the jump is still taken.
- Compares: BEQ uses rs==rt. BNE uses rs≠rt. BGT uses rs>rt, signed DATA_W. BLT uses rs<rt, signed DATA_W.
- taken = valid & ~stall & (state==RUN) & (op is J or JR, or the branch condition is true).
- FSM states:
  - RUN: no pending target.
  - DELAY: target latched; current PC is the delay-slot instruction.
- In RUN, not stalled:
  - If taken and DELAY_SLOT=1: pc←pc+4, tgt_q←target, go to DELAY.
  - If taken and DELAY_SLOT=0: pc←target, stay in RUN.
  - Otherwise: pc←pc+4.
- In DELAY, not stalled: pc←tgt_q, go to RUN.
  - A valid non-SEQ op here is ignored: no second redirect, and slot_err pulses.
- Stall, in either state: pc, state, tgt_q and the error flags hold. taken=0.
- With DELAY_SLOT=0 the DELAY state is unreachable.

## Timing
- Reset values: pc=RESET_VECTOR, state=RUN, tgt_q=0, addr_err=0, slot_err=0. taken is 0 while rst is high.
- rst has priority over stall and over every transfer. Reset asserted during DELAY discards the pending target.
- Redirect latency, measured from the edge that samples a taken op:
  - DELAY_SLOT=0: new pc after 1 edge.
  - DELAY_SLOT=1: pc+4 after 1 edge, target after 2 un-stalled edges.
- addr_err and slot_err are set on the sampling edge and clear on the next edge unless re-triggered.
- A stall between DELAY and the redirect extends the delay-slot cycle. The target is not lost.

## Structure
- Shared package cpu_ctrl_pkg holds:
  - op encodings (OP_SEQ … OP_BLT)
  - FSM state enum (ST_RUN, ST_DELAY)
  - WORD_SHIFT=2
- One sub-module, branch_compare: DATA_W-parametrised, purely combinational. It takes op, rs_val and rt_val and outputs cond. This replaces the old 5-bit index subtractor.
- The top level holds the PC register, the tgt_q register, the FSM, target muxing and the error flags.

## Test plan
- Reset, then 3 un-stalled SEQ cycles, RESET_VECTOR=0x400 -> pc sequence 0x400, 0x404, 0x408, 0x40C.
- DELAY_SLOT=1, pc=0x100, BGT with rs=5, rt=-3, offset=-4 -> taken=1; pc=0x104, then 0xF4. Same op with rs=-3, rt=5 -> taken=0, pc=0x104, then 0x108.
- DELAY_SLOT=0, pc=0x1000_0010, J target=0x0000040 -> next pc=0x1000_0100.
- JR rs_val=0x0000_2003 -> pc redirected to 0x2000 (after the slot when DELAY_SLOT=1), addr_err high for exactly one cycle.
- DELAY_SLOT=1: BEQ taken, then a J in the delay slot with stall held 2 cycles in DELAY -> pc holds through the stall, then goes to the BEQ target. J is ignored and slot_err pulses once.
- rst asserted while in DELAY -> next pc=RESET_VECTOR, state RUN, no later redirect to the stale target.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared control-transfer encodings for the PC/control-transfer unit.
// Holds op codes, FSM states and the word-offset shift amount.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_SEQ = 3'd0,
        OP_J   = 3'd1,
        OP_JR  = 3'd2,
        OP_BEQ = 3'd3,
        OP_BNE = 3'd4,
        OP_BGT = 3'd5,
        OP_BLT = 3'd6
    } op_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DELAY = 1'b1
    } state_e;

    localparam int unsigned WORD_SHIFT = 2;

endpackage

// File: rtl/branch_compare.sv
// Register-value branch condition: equality and signed ordering on rs/rt.
// Outputs 0 for any op that is not a compare-branch.
module branch_compare
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    output logic              cond
);

    always_comb begin
        cond = 1'b0;
        case (op)
            OP_BEQ:  cond = (rs_val == rt_val);
            OP_BNE:  cond = (rs_val != rt_val);
            OP_BGT:  cond = ($signed(rs_val) > $signed(rt_val));
            OP_BLT:  cond = ($signed(rs_val) < $signed(rt_val));
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_control_unit.sv
// Program counter and control-transfer unit: sequential advance, J, JR and
// compare-branches, with an optional single delay-slot instruction.
module pc_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned       ADDR_W       = 32,
    parameter int unsigned       DATA_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter int unsigned       DELAY_SLOT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              valid,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    input  logic [15:0]       offset,
    input  logic [25:0]       target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              taken,
    output logic              addr_err,
    output logic              slot_err
);

    state_e            state_q, state_n;
    logic [ADDR_W-1:0] tgt_q, tgt_n, pc_n;
    logic [ADDR_W-1:0] br_tgt, j_tgt, jr_tgt, xfer_tgt;
    logic [2:0]        op_eff;
    logic              cond, is_jump, addr_err_n, slot_err_n;

    assign op_eff   = valid ? op : OP_SEQ;
    assign pc_plus4 = pc + ADDR_W'(4);

    branch_compare #(.DATA_W(DATA_W)) u_cmp (
        .op     (op_eff),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .cond   (cond)
    );

    assign is_jump = (op_eff == OP_J) || (op_eff == OP_JR);
    assign taken   = valid & ~stall & ~rst & (state_q == ST_RUN) & (is_jump | cond);

    // J keeps the upper PC region; built by overlay so ADDR_W == 28 needs no empty slice
    always_comb begin
        br_tgt = pc_plus4 + (ADDR_W'($signed(offset)) << WORD_SHIFT);
        jr_tgt = ADDR_W'(rs_val) & ~ADDR_W'(3);
        j_tgt        = pc_plus4;
        j_tgt[27:0]  = {target, 2'b00};
        case (op_eff)
            OP_J:    xfer_tgt = j_tgt;
            OP_JR:   xfer_tgt = jr_tgt;
            default: xfer_tgt = br_tgt;
        endcase
    end

    always_comb begin
        state_n    = state_q;
        pc_n       = pc;
        tgt_n      = tgt_q;
        addr_err_n = addr_err;
        slot_err_n = slot_err;
        if (!stall) begin
            addr_err_n = taken && (op_eff == OP_JR) && (rs_val[1:0] != 2'b00);
            slot_err_n = (state_q == ST_DELAY) &&
                         (op_eff inside {OP_J, OP_JR, OP_BEQ, OP_BNE, OP_BGT, OP_BLT});
            case (state_q)
                ST_RUN: begin
                    if (taken && DELAY_SLOT != 0) begin
                        pc_n    = pc_plus4;
                        tgt_n   = xfer_tgt;
                        state_n = ST_DELAY;
                    end else if (taken) begin
                        pc_n = xfer_tgt;
                    end else begin
                        pc_n = pc_plus4;
                    end
                end
                ST_DELAY: begin
                    pc_n    = tgt_q;
                    state_n = ST_RUN;
                end
                default: state_n = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            pc       <= RESET_VECTOR;
            tgt_q    <= '0;
            addr_err <= 1'b0;
            slot_err <= 1'b0;
        end else begin
            state_q  <= state_n;
            pc       <= pc_n;
            tgt_q    <= tgt_n;
            addr_err <= addr_err_n;
            slot_err <= slot_err_n;
        end
    end

endmodule

// File: tb/tb_pc_control_unit.sv
// Bench for pc_control_unit: one instance with a delay slot, one without,
// driven by directed and random stimulus against a behavioural model.
module tb_pc_control_unit;

    typedef struct packed {
        logic        valid;
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [15:0] off;
        logic [25:0] tg;
        logic        stall;
    } in_t;

    logic        clk, rst;
    in_t         in0, in1;
    logic [31:0] pc0, pc1, p40, p41;
    logic        tk0, tk1, ae0, ae1, se0, se1;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_pc   [2];
    logic [31:0] m_tgt  [2];
    bit          m_pend [2];
    bit          m_ae   [2];
    bit          m_se   [2];

    localparam logic [31:0] RV = 32'h400;

    pc_control_unit #(.ADDR_W(32), .DATA_W(32), .RESET_VECTOR(RV), .DELAY_SLOT(0)) dut0 (
        .clk(clk), .rst(rst), .stall(in0.stall), .valid(in0.valid), .op(in0.op),
        .rs_val(in0.rs), .rt_val(in0.rt), .offset(in0.off), .target(in0.tg),
        .pc(pc0), .pc_plus4(p40), .taken(tk0), .addr_err(ae0), .slot_err(se0)
    );

    pc_control_unit #(.ADDR_W(32), .DATA_W(32), .RESET_VECTOR(RV), .DELAY_SLOT(1)) dut1 (
        .clk(clk), .rst(rst), .stall(in1.stall), .valid(in1.valid), .op(in1.op),
        .rs_val(in1.rs), .rt_val(in1.rt), .offset(in1.off), .target(in1.tg),
        .pc(pc1), .pc_plus4(p41), .taken(tk1), .addr_err(ae1), .slot_err(se1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic in_t mk(input bit v, input int o, input logic [31:0] rs,
                               input logic [31:0] rt, input logic [15:0] off,
                               input logic [25:0] tg, input bit st);
        in_t a;
        a.valid = v; a.op = 3'(o); a.rs = rs; a.rt = rt;
        a.off = off; a.tg = tg; a.stall = st;
        return a;
    endfunction

    function automatic in_t idle();
        return mk(1'b0, 0, 32'd0, 32'd0, 16'd0, 26'd0, 1'b0);
    endfunction

    // Decoded behaviour of one instruction: does it transfer, and to where.
    task automatic decode(input in_t a, input logic [31:0] cur, output bit xfer,
                          output logic [31:0] dest, output int opv);
        logic [31:0] nxt;
        nxt  = cur + 32'd4;
        opv  = a.valid ? int'(a.op) : 0;
        xfer = 1'b0;
        dest = nxt + 32'($signed(a.off)) * 32'd4;
        case (opv)
            1: begin xfer = 1'b1; dest = {nxt[31:28], a.tg, 2'b00}; end
            2: begin xfer = 1'b1; dest = a.rs & 32'hFFFF_FFFC; end
            3: xfer = (a.rs == a.rt);
            4: xfer = (a.rs != a.rt);
            5: xfer = ($signed(a.rs) > $signed(a.rt));
            6: xfer = ($signed(a.rs) < $signed(a.rt));
            default: xfer = 1'b0;
        endcase
    endtask

    task automatic cycle(input in_t a0, input in_t a1, input bit r);
        in_t         a;
        bit          xfer, exp_tk;
        logic [31:0] dest;
        int          opv;
        in0 = a0; in1 = a1; rst = r;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            a = (i == 0) ? a0 : a1;
            decode(a, m_pc[i], xfer, dest, opv);
            exp_tk = !r && !a.stall && !m_pend[i] && xfer;
            check($sformatf("taken%0d", i), 32'((i == 0) ? tk0 : tk1), 32'(exp_tk));
            if (!r)
                check($sformatf("pc_plus4_%0d", i), (i == 0) ? p40 : p41, m_pc[i] + 32'd4);
            if (r) begin
                m_pc[i] = RV; m_pend[i] = 1'b0; m_tgt[i] = '0;
                m_ae[i] = 1'b0; m_se[i] = 1'b0;
            end else if (!a.stall) begin
                m_ae[i] = exp_tk && opv == 2 && a.rs[1:0] != 2'b00;
                m_se[i] = m_pend[i] && opv >= 1 && opv <= 6;
                if (m_pend[i]) begin
                    m_pc[i] = m_tgt[i]; m_pend[i] = 1'b0;
                end else if (exp_tk && i == 1) begin
                    m_pc[i] = m_pc[i] + 32'd4; m_tgt[i] = dest; m_pend[i] = 1'b1;
                end else if (exp_tk) begin
                    m_pc[i] = dest;
                end else begin
                    m_pc[i] = m_pc[i] + 32'd4;
                end
            end
        end
        @(posedge clk);
        #1;
        check("pc0", pc0, m_pc[0]);
        check("pc1", pc1, m_pc[1]);
        check("addr_err0", 32'(ae0), 32'(m_ae[0]));
        check("addr_err1", 32'(ae1), 32'(m_ae[1]));
        check("slot_err0", 32'(se0), 32'(m_se[0]));
        check("slot_err1", 32'(se1), 32'(m_se[1]));
    endtask

    function automatic in_t rnd();
        in_t a;
        a.valid = ($urandom_range(0, 7) != 0);
        a.op    = 3'($urandom_range(0, 7));
        a.rs    = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 7)) - 32'd4;
        a.rt    = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 7)) - 32'd4;
        a.off   = 16'($urandom);
        a.tg    = 26'($urandom);
        a.stall = ($urandom_range(0, 5) == 0);
        return a;
    endfunction

    initial begin
        // reset with a J presented: must not be taken
        cycle(mk(1, 1, 0, 0, 0, 26'h40, 0), mk(1, 1, 0, 0, 0, 26'h40, 0), 1'b1);
        cycle(idle(), idle(), 1'b1);
        check("reset_pc1", pc1, 32'h400);
        repeat (3) cycle(idle(), idle(), 1'b0);
        check("seq_pc0", pc0, 32'h40C);
        check("seq_pc1", pc1, 32'h40C);

        // steer dut1 to 0x100 through a slot, dut0 to 0x1000_0010 directly
        cycle(mk(1, 2, 32'h1000_0010, 0, 0, 0, 0), mk(1, 2, 32'h100, 0, 0, 0, 0), 1'b0);
        check("jr_imm_pc0", pc0, 32'h1000_0010);
        check("jr_slot_pc1", pc1, 32'h410);
        cycle(mk(1, 1, 0, 0, 0, 26'h40, 0), idle(), 1'b0);
        check("j_pc0", pc0, 32'h1000_0100);
        check("jr_done_pc1", pc1, 32'h100);

        cycle(idle(), mk(1, 5, 32'd5, -32'sd3, 16'hFFFC, 0, 0), 1'b0);
        check("bgt_slot_pc1", pc1, 32'h104);
        cycle(idle(), idle(), 1'b0);
        check("bgt_tgt_pc1", pc1, 32'hF4);

        cycle(idle(), mk(1, 2, 32'h100, 0, 0, 0, 0), 1'b0);
        cycle(idle(), idle(), 1'b0);
        cycle(idle(), mk(1, 5, -32'sd3, 32'd5, 16'hFFFC, 0, 0), 1'b0);
        check("bgt_nt_pc1", pc1, 32'h104);
        cycle(idle(), idle(), 1'b0);
        check("bgt_nt2_pc1", pc1, 32'h108);

        // misaligned JR: taken anyway, one-cycle error pulse
        cycle(mk(1, 2, 32'h2003, 0, 0, 0, 0), mk(1, 2, 32'h2003, 0, 0, 0, 0), 1'b0);
        check("jr_mis_pc0", pc0, 32'h2000);
        check("jr_mis_ae0", 32'(ae0), 32'd1);
        cycle(idle(), idle(), 1'b0);
        check("jr_mis_pc1", pc1, 32'h2000);
        check("jr_mis_ae0_clr", 32'(ae0), 32'd0);

        // BEQ, then a J in the slot held by two stall cycles
        cycle(idle(), mk(1, 3, 32'd7, 32'd7, 16'd8, 0, 0), 1'b0);
        cycle(idle(), mk(1, 1, 0, 0, 0, 26'h123, 1), 1'b0);
        cycle(idle(), mk(1, 1, 0, 0, 0, 26'h123, 1), 1'b0);
        check("stall_hold_pc1", pc1, 32'h2004);
        cycle(idle(), mk(1, 1, 0, 0, 0, 26'h123, 0), 1'b0);
        check("slot_tgt_pc1", pc1, 32'h2024);
        check("slot_err1", 32'(se1), 32'd1);
        cycle(idle(), idle(), 1'b0);
        check("slot_err1_clr", 32'(se1), 32'd0);

        // reset while a target is pending discards it
        cycle(idle(), mk(1, 3, 32'd7, 32'd7, 16'd8, 0, 0), 1'b0);
        cycle(idle(), idle(), 1'b1);
        check("rst_delay_pc1", pc1, 32'h400);
        cycle(idle(), idle(), 1'b0);
        check("rst_no_stale_pc1", pc1, 32'h404);

        for (int n = 0; n < 600; n++)
            cycle(rnd(), rnd(), ($urandom_range(0, 63) == 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
